// File: rtl/shift_sequencer_if.sv
// Command/response bundle for shift_sequencer: two requester command
// channels and one result channel, all valid/ready handshakes.
// master = client/consumer side, slave = sequencer side.
interface shift_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_data;
    logic [1:0]       req0_mode;
    logic [CNT_W-1:0] req0_count;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_data;
    logic [1:0]       req1_mode;
    logic [CNT_W-1:0] req1_count;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_id;

    modport master (
        output req0_valid, req0_data, req0_mode, req0_count,
        output req1_valid, req1_data, req1_mode, req1_count,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req0_valid, req0_data, req0_mode, req0_count,
        input  req1_valid, req1_data, req1_mode, req1_count,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: two-requester round-robin front end for the shifter.
// A granted command is captured, shifted one bit per cycle in a working
// register, and the result is held on the response channel until taken.
// Optional build macro SHIFT_SEQ_ROTATE_EN: mode 2 becomes rotate-left
// instead of arithmetic (= logical) left.
module shift_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic                clk,
    input  logic                reset,
    shift_sequencer_if.slave    bus,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r, state_next_s;
    logic [WIDTH-1:0] work_r, work_next_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;
    logic [1:0]       mode_r, mode_next_s;
    logic             id_r, id_next_s;
    logic             last_r, last_next_s;
    logic [WIDTH-1:0] rsp_data_r, rsp_data_next_s;
    logic             rsp_id_r, rsp_id_next_s;

    logic             grant0_s, grant1_s;
    logic [WIDTH-1:0] cap_data_s;
    logic [1:0]       cap_mode_s;
    logic [CNT_W-1:0] cap_count_s;
    logic [WIDTH-1:0] step_s;

    // One single-bit shift step for the given mode.
    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] d,
                                                    input logic [1:0] mode);
        logic [WIDTH-1:0] r;
        case (mode)
            2'd0:    r = {d[WIDTH-2:0], 1'b0};
            2'd1:    r = {1'b0, d[WIDTH-1:1]};
`ifdef SHIFT_SEQ_ROTATE_EN
            2'd2:    r = {d[WIDTH-2:0], d[WIDTH-1]};
`else
            2'd2:    r = {d[WIDTH-2:0], 1'b0};
`endif
            2'd3:    r = {d[WIDTH-1], d[WIDTH-1:1]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Round-robin grant: only in IDLE and never while reset is asserted;
    // on contention the requester not granted last wins (last_r=1 favours req0).
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if ((state_r == IDLE) && !reset) begin
            if (bus.req0_valid && bus.req1_valid) begin
                if (last_r) begin
                    grant0_s = 1'b1;
                end else begin
                    grant1_s = 1'b1;
                end
            end else if (bus.req0_valid) begin
                grant0_s = 1'b1;
            end else if (bus.req1_valid) begin
                grant1_s = 1'b1;
            end else begin
                grant0_s = 1'b0;
                grant1_s = 1'b0;
            end
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Select the granted requester's command fields for capture.
    always_comb begin
        cap_data_s  = bus.req0_data;
        cap_mode_s  = bus.req0_mode;
        cap_count_s = bus.req0_count;
        if (grant1_s) begin
            cap_data_s  = bus.req1_data;
            cap_mode_s  = bus.req1_mode;
            cap_count_s = bus.req1_count;
        end else begin
            cap_data_s  = bus.req0_data;
            cap_mode_s  = bus.req0_mode;
            cap_count_s = bus.req0_count;
        end
    end

    assign step_s = shift_step(work_r, mode_r);

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_next_s    = state_r;
        work_next_s     = work_r;
        cnt_next_s      = cnt_r;
        mode_next_s     = mode_r;
        id_next_s       = id_r;
        last_next_s     = last_r;
        rsp_data_next_s = rsp_data_r;
        rsp_id_next_s   = rsp_id_r;
        case (state_r)
            IDLE: begin
                if (grant0_s || grant1_s) begin
                    work_next_s = cap_data_s;
                    cnt_next_s  = cap_count_s;
                    mode_next_s = cap_mode_s;
                    id_next_s   = grant1_s;
                    last_next_s = grant1_s;
                    if (cap_count_s == {CNT_W{1'b0}}) begin
                        // Zero count: the operand itself is the result.
                        rsp_data_next_s = cap_data_s;
                        rsp_id_next_s   = grant1_s;
                        state_next_s    = DONE;
                    end else begin
                        state_next_s = SHIFT;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                work_next_s = step_s;
                cnt_next_s  = cnt_r - CNT_W'(1);
                if (cnt_r == CNT_W'(1)) begin
                    // Last step: result register loads only on entry to DONE.
                    rsp_data_next_s = step_s;
                    rsp_id_next_s   = id_r;
                    state_next_s    = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any command in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            work_r     <= {WIDTH{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            mode_r     <= 2'd0;
            id_r       <= 1'b0;
            last_r     <= 1'b1;
            rsp_data_r <= {WIDTH{1'b0}};
            rsp_id_r   <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            work_r     <= work_next_s;
            cnt_r      <= cnt_next_s;
            mode_r     <= mode_next_s;
            id_r       <= id_next_s;
            last_r     <= last_next_s;
            rsp_data_r <= rsp_data_next_s;
            rsp_id_r   <= rsp_id_next_s;
        end
    end

    assign bus.req0_ready = grant0_s;
    assign bus.req1_ready = grant1_s;
    assign bus.rsp_valid  = (state_r == DONE);
    assign bus.rsp_data   = rsp_data_r;
    assign bus.rsp_id     = rsp_id_r;
    assign busy           = (state_r != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: scoreboard of expected results
// pushed at each accept and checked while the response is presented.
module tb_shift_sequencer;
    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset;
    logic busy;

    shift_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int check_count = 0;
    int error_count = 0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        if (obs !== exp) begin
            error_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [15:0] data;
        logic        id;
        int          count;
        int          acc_cycle;
    } exp_t;

    exp_t sb_q[$];

    function automatic logic [15:0] model_shift(input logic [15:0] d, input logic [1:0] m, input int n);
        logic [15:0] v;
        v = d;
        for (int i = 0; i < n; i++) begin
            case (m)
                2'd0: v = {v[14:0], 1'b0};
                2'd1: v = {1'b0, v[15:1]};
`ifdef SHIFT_SEQ_ROTATE_EN
                2'd2: v = {v[14:0], v[15]};
`else
                2'd2: v = {v[14:0], 1'b0};
`endif
                default: v = {v[15], v[15:1]};
            endcase
        end
        return v;
    endfunction

    int          cycle = 0;
    logic        tb_last = 1'b1;
    logic        prev_valid = 1'b0;
    logic        expect_drop = 1'b0;
    logic [15:0] last_rsp_data = 16'h0000;
    logic        last_rsp_id = 1'b0;
    int          rsp_total = 0;
    logic        exp_grant;
    exp_t        e;

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    // Monitor: grant model, scoreboard push on accept, checks on response.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            check_value("ready0_in_reset", bus.req0_ready, 1'b0);
            check_value("ready1_in_reset", bus.req1_ready, 1'b0);
            check_value("rsp_valid_in_reset", bus.rsp_valid, 1'b0);
            sb_q.delete();
            tb_last     = 1'b1;
            prev_valid  = 1'b0;
            expect_drop = 1'b0;
        end else begin
            if (expect_drop) begin
                check_value("rsp_drop_after_handshake", bus.rsp_valid, 1'b0);
                expect_drop = 1'b0;
            end
            if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) begin
                check_value("single_ready", bus.req0_ready & bus.req1_ready, 1'b0);
                if (bus.req0_valid && bus.req1_valid) exp_grant = ~tb_last;
                else exp_grant = bus.req0_valid ? 1'b0 : 1'b1;
                check_value("grant", bus.req1_ready, exp_grant);
                tb_last = exp_grant;
                if (exp_grant) begin
                    e.data  = model_shift(bus.req1_data, bus.req1_mode, int'(bus.req1_count));
                    e.count = int'(bus.req1_count);
                end else begin
                    e.data  = model_shift(bus.req0_data, bus.req0_mode, int'(bus.req0_count));
                    e.count = int'(bus.req0_count);
                end
                e.id        = exp_grant;
                e.acc_cycle = cycle;
                sb_q.push_back(e);
            end
            if (bus.rsp_valid) begin
                if (sb_q.size() == 0) begin
                    check_value("rsp_unexpected", bus.rsp_valid, 1'b0);
                end else begin
                    if (!prev_valid)
                        check_value("latency", cycle - sb_q[0].acc_cycle, sb_q[0].count + 1);
                    check_value("rsp_data", bus.rsp_data, sb_q[0].data);
                    check_value("rsp_id", bus.rsp_id, sb_q[0].id);
                    check_value("ready_low_in_done", bus.req0_ready | bus.req1_ready, 1'b0);
                    check_value("busy_in_done", busy, 1'b1);
                    if (bus.rsp_ready) begin
                        last_rsp_data = bus.rsp_data;
                        last_rsp_id   = bus.rsp_id;
                        void'(sb_q.pop_front());
                        rsp_total++;
                        expect_drop = 1'b1;
                    end
                end
            end
            prev_valid = bus.rsp_valid;
        end
    end

    // Present one command on requester r and hold it until accepted.
    task automatic drive_req(input int r, input logic [15:0] d, input logic [1:0] m, input logic [3:0] c);
        logic ok;
        ok = 1'b0;
        if (r == 0) begin
            bus.req0_data = d; bus.req0_mode = m; bus.req0_count = c; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_data = d; bus.req1_mode = m; bus.req1_count = c; bus.req1_valid = 1'b1;
        end
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if ((r == 0) ? bus.req0_ready : bus.req1_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_value("accept_timeout", ok, 1'b1);
        @(posedge clk);
        #1;
        if (r == 0) bus.req0_valid = 1'b0;
        else bus.req1_valid = 1'b0;
    endtask

    // Wait until all expected responses are drained and the block is idle.
    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(posedge clk);
            #2;
            if (sb_q.size() == 0 && !busy) begin
                done = 1'b1;
                break;
            end
        end
        check_value("idle_timeout", done, 1'b1);
    endtask

    int   rsp_before;
    logic seen;

    initial begin
        reset = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_data = 16'hFFFF; bus.req0_mode = 2'd0; bus.req0_count = 4'd1;
        bus.req1_valid = 1'b0; bus.req1_data = 16'h0000; bus.req1_mode = 2'd0; bus.req1_count = 4'd0;
        bus.rsp_ready  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_value("reset_rsp_valid", bus.rsp_valid, 1'b0);
        check_value("reset_rsp_data", bus.rsp_data, 16'h0000);
        check_value("reset_rsp_id", bus.rsp_id, 1'b0);
        check_value("reset_busy", busy, 1'b0);
        check_value("reset_req0_ready", bus.req0_ready, 1'b0);
        bus.req0_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;

        // Single command: arithmetic right by 4.
        drive_req(0, 16'h8001, 2'd3, 4'd4);
        wait_idle();
        check_value("single_const_data", last_rsp_data, 16'hF800);
        check_value("single_const_id", last_rsp_id, 1'b0);

        // Zero count on requester 1.
        drive_req(1, 16'h1234, 2'd0, 4'd0);
        wait_idle();
        check_value("zero_const_data", last_rsp_data, 16'h1234);
        check_value("zero_const_id", last_rsp_id, 1'b1);

        // Mode 2 boundary.
        drive_req(0, 16'hC001, 2'd2, 4'd1);
        wait_idle();
`ifdef SHIFT_SEQ_ROTATE_EN
        check_value("mode2_const", last_rsp_data, 16'h8003);
`else
        check_value("mode2_const", last_rsp_data, 16'h8002);
`endif

        // Contention: four back-to-back commands on each requester.
        rsp_before = rsp_total;
        fork
            begin
                for (int k = 0; k < 4; k++)
                    drive_req(0, 16'h1111 * 16'(k + 1), 2'(k), 4'(k % 3));
            end
            begin
                for (int k = 0; k < 4; k++)
                    drive_req(1, 16'h9C3A ^ 16'(k * 16'h0505), 2'(3 - k), 4'(k + 1));
            end
        join
        wait_idle();
        check_value("contention_count", rsp_total - rsp_before, 8);

        // Backpressure: result held 6 cycles while req0 waits.
        bus.rsp_ready = 1'b0;
        drive_req(1, 16'h00F0, 2'd1, 4'd2);
        seen = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check_value("bp_rsp_seen", seen, 1'b1);
        #1;
        bus.req0_data = 16'h0F0F; bus.req0_mode = 2'd0; bus.req0_count = 4'd3; bus.req0_valid = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check_value("bp_req0_ready_low", bus.req0_ready, 1'b0);
        end
        rsp_before = rsp_total;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        @(posedge clk);
        #2;
        check_value("bp_completed", rsp_total - rsp_before, 1);
        check_value("bp_const_data", last_rsp_data, 16'h003C);
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus.req0_ready) begin
                seen = 1'b1;
                break;
            end
        end
        check_value("bp_waiting_req_accepted", seen, 1'b1);
        @(posedge clk);
        #1 bus.req0_valid = 1'b0;
        wait_idle();

        // Reset in the middle of a count-10 shift.
        drive_req(0, 16'hA5A5, 2'd1, 4'd10);
        rsp_before = rsp_total;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #2;
        check_value("busy_after_reset", busy, 1'b0);
        check_value("rsp_valid_after_reset", bus.rsp_valid, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        drive_req(1, 16'h0001, 2'd0, 4'd15);
        wait_idle();
        check_value("reset_no_response", rsp_total - rsp_before, 1);
        check_value("post_reset_id", last_rsp_id, 1'b1);
        check_value("post_reset_data", last_rsp_data, 16'h8000);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
